// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: op codes, FSM states and the
// multi-pass microsequence constants.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD     = 3'b000,
    OP_SUB     = 3'b001,
    OP_AND     = 3'b010,
    OP_OR      = 3'b011,
    OP_SRL     = 3'b100,
    OP_SRA     = 3'b101,
    OP_ABSDIFF = 3'b110,
    OP_NOR     = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int NOR_PASSES = 3;

  // ALUOp driven on the first pass of each request.
  function automatic logic [2:0] first_pass_op(input op_e op);
    case (op)
      OP_ABSDIFF: first_pass_op = OP_SUB;
      OP_NOR:     first_pass_op = OP_OR;
      default:    first_pass_op = op;
    endcase
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Request, ALU and result signals of the ALU sequencer. The slave modport is
// the sequencer; the master modport is the requester/ALU/consumer side.
interface alu_sequencer_if #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [2:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [2:0]       alu_op;
  logic [31:0]      alu_c;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic [TAG_W-1:0] res_tag;
  logic [CNT_W-1:0] done_count;

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_tag, alu_c, res_ready,
    output in_ready, alu_a, alu_b, alu_op, res_valid, res_data, res_tag, done_count
  );

  modport master (
    output in_valid, in_a, in_b, in_op, in_tag, alu_c, res_ready,
    input  in_ready, alu_a, alu_b, alu_op, res_valid, res_data, res_tag, done_count
  );
endinterface

// File: rtl/alu_sequencer.sv
// Drives an external combinational ALU one pass per cycle, building ABSDIFF
// and NOR out of SUB/OR passes, and returns tagged results.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic reset,
  alu_sequencer_if.slave bus
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [1:0]       pass_q, pass_d;
  logic [31:0]      t_q, t_d;
  logic [31:0]      alu_a_q, alu_a_d;
  logic [31:0]      alu_b_q, alu_b_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic [31:0]      res_data_q, res_data_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_pass;
  logic             nor_final;

  assign bus.in_ready   = (state_q == S_IDLE);
  assign bus.res_valid  = (state_q == S_DONE);
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_tag    = res_tag_q;
  assign bus.done_count = cnt_q;

  // ABSDIFF stops after the subtraction unless it came out negative.
  always_comb begin
    case (op_q)
      OP_ABSDIFF: last_pass = (pass_q == 2'd1) || !bus.alu_c[31];
      OP_NOR:     last_pass = (pass_q == 2'(NOR_PASSES - 1));
      default:    last_pass = 1'b1;
    endcase
  end

  assign nor_final = (op_q == OP_NOR) && (pass_q == 2'd1);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    tag_d      = tag_q;
    pass_d     = pass_q;
    t_d        = t_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    res_data_d = res_data_q;
    res_tag_d  = res_tag_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          op_d     = op_e'(bus.in_op);
          tag_d    = bus.in_tag;
          pass_d   = 2'd0;
          alu_a_d  = bus.in_a;
          alu_b_d  = bus.in_b;
          alu_op_d = first_pass_op(op_e'(bus.in_op));
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        t_d = bus.alu_c;
        if (last_pass) begin
          res_data_d = bus.alu_c;
          res_tag_d  = tag_q;
          state_d    = S_DONE;
        end else begin
          // Follow-on passes: negate (0 - t), then for NOR subtract one (t - 1).
          pass_d   = 2'(pass_q + 2'd1);
          alu_op_d = OP_SUB;
          alu_a_d  = nor_final ? bus.alu_c : 32'd0;
          alu_b_d  = nor_final ? 32'd1 : bus.alu_c;
        end
      end
      S_DONE: begin
        if (bus.res_ready) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      op_q       <= OP_ADD;
      tag_q      <= '0;
      pass_q     <= '0;
      t_q        <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      res_data_q <= '0;
      res_tag_q  <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      tag_q      <= tag_d;
      pass_q     <= pass_d;
      t_q        <= t_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      res_data_q <= res_data_d;
      res_tag_q  <= res_tag_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural ALU attached.
module tb_alu_sequencer;
  localparam int TAG_W = 4;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  alu_sequencer_if #(.TAG_W(TAG_W), .CNT_W(CNT_W)) ifc ();

  alu_sequencer #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  // Combinational ALU
  always_comb begin
    ifc.alu_c = 32'd0;
    case (ifc.alu_op)
      3'b000: ifc.alu_c = ifc.alu_a + ifc.alu_b;
      3'b001: ifc.alu_c = ifc.alu_a - ifc.alu_b;
      3'b010: ifc.alu_c = ifc.alu_a & ifc.alu_b;
      3'b011: ifc.alu_c = ifc.alu_a | ifc.alu_b;
      3'b100: ifc.alu_c = ifc.alu_a >> ifc.alu_b;
      3'b101: ifc.alu_c = $unsigned($signed(ifc.alu_a) >>> ifc.alu_b);
      default: ifc.alu_c = 32'd0;
    endcase
  end

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
  } exp_t;

  typedef struct {
    logic [2:0]       op;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
    logic [31:0]      exp;
    int               passes;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[13];
  int tests = 0;
  int fails = 0;
  int exp_count = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Scoreboard: compare every result handshake against the oldest expectation.
  always @(negedge clk) begin
    if (reset && ifc.res_valid && ifc.res_ready) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_result: got data %h tag %h, expected no result", ifc.res_data, ifc.res_tag);
      end else begin
        mon_e = sb.pop_front();
        if (ifc.res_data !== mon_e.data || ifc.res_tag !== mon_e.tag) begin
          fails++;
          $display("FAIL result: got data %h tag %h, expected data %h tag %h",
                   ifc.res_data, ifc.res_tag, mon_e.data, mon_e.tag);
        end
        $display("[TB] result data=%h tag=%h", ifc.res_data, ifc.res_tag);
      end
    end
  end

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    d = a - b;
    if (op == 3'b110) ref_result = d[31] ? (32'd0 - d) : d;
    else              ref_result = ~(a | b);
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!ifc.in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_wait", 32'(ifc.in_ready), 32'd1);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!ifc.res_valid && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag);
    ifc.in_valid = 1'b1;
    ifc.in_op    = op;
    ifc.in_a     = a;
    ifc.in_b     = b;
    ifc.in_tag   = tag;
  endtask

  task automatic run_op(input vec_t v);
    int lat;
    wait_ready();
    drive(v.op, v.a, v.b, v.tag);
    @(posedge clk);
    sb.push_back('{v.exp, v.tag});
    #1 ifc.in_valid = 1'b0;
    wait_valid(lat);
    check("latency", 32'(lat), 32'(v.passes));
    @(posedge clk); #1;
    exp_count++;
    check("done_count", 32'(ifc.done_count), 32'(exp_count));
    $display("[TB] op=%0d a=%h b=%h tag=%h latency=%0d", v.op, v.a, v.b, v.tag, lat);
  endtask

  initial begin
    int lat;
    vec_t v;
    logic [31:0] ra, rb, rd;
    logic [2:0]  rop;

    vecs[0]  = '{3'b000, 32'h7FFFFFFF, 32'h00000001, 4'h5, 32'h80000000, 1};
    vecs[1]  = '{3'b110, 32'h00000003, 32'h0000000A, 4'h1, 32'h00000007, 2};
    vecs[2]  = '{3'b110, 32'h0000000A, 32'h00000003, 4'h2, 32'h00000007, 1};
    vecs[3]  = '{3'b110, 32'h80000000, 32'h00000000, 4'h3, 32'h80000000, 2};
    vecs[4]  = '{3'b111, 32'h0F0F0000, 32'h000000F0, 4'h4, 32'hF0F0FF0F, 3};
    vecs[5]  = '{3'b101, 32'h80000000, 32'h00000004, 4'h6, 32'hF8000000, 1};
    vecs[6]  = '{3'b100, 32'h80000000, 32'h00000004, 4'h7, 32'h08000000, 1};
    vecs[7]  = '{3'b001, 32'h00000005, 32'h00000007, 4'h8, 32'hFFFFFFFE, 1};
    vecs[8]  = '{3'b010, 32'hF0F0F0F0, 32'hFF00FF00, 4'h9, 32'hF000F000, 1};
    vecs[9]  = '{3'b011, 32'h12340000, 32'h00005678, 4'hA, 32'h12345678, 1};
    vecs[10] = '{3'b100, 32'hFFFFFFFF, 32'h00000020, 4'hB, 32'h00000000, 1};
    vecs[11] = '{3'b110, 32'h00000005, 32'h00000005, 4'hC, 32'h00000000, 1};
    vecs[12] = '{3'b111, 32'h00000000, 32'h00000000, 4'hD, 32'hFFFFFFFF, 3};

    ifc.in_valid  = 1'b0;
    ifc.in_a      = '0;
    ifc.in_b      = '0;
    ifc.in_op     = '0;
    ifc.in_tag    = '0;
    ifc.res_ready = 1'b1;
    reset         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",   32'(ifc.in_ready), 32'd1);
    check("rst_res_valid",  32'(ifc.res_valid), 32'd0);
    check("rst_res_data",   ifc.res_data, 32'd0);
    check("rst_res_tag",    32'(ifc.res_tag), 32'd0);
    check("rst_alu_a",      ifc.alu_a, 32'd0);
    check("rst_alu_b",      ifc.alu_b, 32'd0);
    check("rst_alu_op",     32'(ifc.alu_op), 32'd0);
    check("rst_done_count", 32'(ifc.done_count), 32'd0);
    reset = 1'b1;

    foreach (vecs[i]) run_op(vecs[i]);

    for (int i = 0; i < 6; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      rop = (i % 2 == 0) ? 3'b110 : 3'b111;
      rd  = ra - rb;
      v   = '{rop, ra, rb, 4'(i), ref_result(rop, ra, rb),
             (rop == 3'b111) ? 3 : (rd[31] ? 2 : 1)};
      run_op(v);
    end

    // NOR pass sequence as seen by the ALU
    wait_ready();
    drive(3'b111, 32'h0F0F0000, 32'h000000F0, 4'hE);
    @(posedge clk);
    sb.push_back('{32'hF0F0FF0F, 4'hE});
    #1 ifc.in_valid = 1'b0;
    check("nor_pass1_op", 32'(ifc.alu_op), 32'd3);
    @(posedge clk); #1;
    check("nor_pass2_op", 32'(ifc.alu_op), 32'd1);
    @(posedge clk); #1;
    check("nor_pass3_op", 32'(ifc.alu_op), 32'd1);
    check("nor_not_yet_valid", 32'(ifc.res_valid), 32'd0);
    @(posedge clk); #1;
    check("nor_valid_at_p3", 32'(ifc.res_valid), 32'd1);
    @(posedge clk); #1;
    exp_count++;
    check("nor_done_count", 32'(ifc.done_count), 32'(exp_count));

    // Back-pressure in DONE with a competing request held valid
    ifc.res_ready = 1'b0;
    wait_ready();
    drive(3'b000, 32'd1, 32'd2, 4'h9);
    @(posedge clk);
    sb.push_back('{32'd3, 4'h9});
    #1 ifc.in_valid = 1'b0;
    wait_valid(lat);
    check("bp_latency", 32'(lat), 32'd1);
    drive(3'b001, 32'd9, 32'd4, 4'h3);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_res_data",  ifc.res_data, 32'd3);
      check("bp_res_tag",   32'(ifc.res_tag), 32'h9);
      check("bp_in_ready",  32'(ifc.in_ready), 32'd0);
      check("bp_res_valid", 32'(ifc.res_valid), 32'd1);
    end
    check("bp_count_held", 32'(ifc.done_count), 32'(exp_count));
    ifc.res_ready = 1'b1;
    @(posedge clk); #1;
    exp_count++;
    check("bp_idle_in_ready",  32'(ifc.in_ready), 32'd1);
    check("bp_idle_res_valid", 32'(ifc.res_valid), 32'd0);
    check("bp_done_count",     32'(ifc.done_count), 32'(exp_count));
    sb.push_back('{32'd5, 4'h3});
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    check("bp_pending_accepted", 32'(ifc.in_ready), 32'd0);
    wait_valid(lat);
    check("bp_pending_latency", 32'(lat), 32'd1);
    @(posedge clk); #1;
    exp_count++;
    check("bp_pending_count", 32'(ifc.done_count), 32'(exp_count));

    // Reset during NOR pass 2 abandons the op
    wait_ready();
    drive(3'b111, 32'h12345678, 32'h0000FFFF, 4'h7);
    @(posedge clk);
    #1 ifc.in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    exp_count = 0;
    check("abort_in_ready",   32'(ifc.in_ready), 32'd1);
    check("abort_res_valid",  32'(ifc.res_valid), 32'd0);
    check("abort_done_count", 32'(ifc.done_count), 32'd0);
    repeat (8) @(posedge clk);
    #1;
    check("abort_no_result", 32'(ifc.res_valid), 32'd0);
    run_op(vecs[0]);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
